// File: rtl/cntr_byte_readout_if.sv
`default_nettype none
// ============================================================================
// Module   : cntr_byte_readout_if
// Purpose  : Byte-stream bus between the counter readout and its consumer.
//            The producer drives the byte, its valid flag and the channel, byte
//            and end-of-frame tags. The consumer returns the ready flag.
// Ports    : master - byte_out, byte_valid, byte_ch, byte_idx, byte_last
//                     as outputs; rd_ready as an input
//            slave  - the same signals with the directions reversed
// Revision : 1.0 - initial release
// ============================================================================
interface cntr_byte_readout_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 27
);
  localparam int NUM_BYTES = (CNT_W + 7) / 8;
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  logic [7:0]        byte_out;
  logic              byte_valid;
  logic [CH_W-1:0]   byte_ch;
  logic [BYTE_W-1:0] byte_idx;
  logic              byte_last;
  logic              rd_ready;

  modport master (
    output byte_out,
    output byte_valid,
    output byte_ch,
    output byte_idx,
    output byte_last,
    input  rd_ready
  );

  modport slave (
    input  byte_out,
    input  byte_valid,
    input  byte_ch,
    input  byte_idx,
    input  byte_last,
    output rd_ready
  );
endinterface
`default_nettype wire

// File: rtl/cntr_byte_readout.sv
`default_nettype none
// ============================================================================
// Module   : cntr_byte_readout
// Purpose  : Snapshot-and-stream readout for NUM_CH free-running counters.
//            A snap_req latches every counter value and the channel-enable
//            mask together. The enabled channels are then sent LSB byte first
//            over one registered 8-bit valid/ready byte stream.
// Ports    : clk        - system clock, rising edge
//            rst_n      - synchronous active-low reset
//            cntr_val   - packed counter values, channel c at [c*CNT_W +: CNT_W]
//            ch_mask    - channel enables, sampled with the snapshot
//            snap_req   - single-cycle frame request
//            bus        - byte stream (master side of cntr_byte_readout_if)
//            busy       - frame in progress (SEND or DONE)
//            frame_done - one-cycle pulse at the end of a frame
//            snap_drop  - one-cycle pulse when a snap_req was ignored
// Revision : 1.0 - initial release
// ============================================================================
module cntr_byte_readout #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 27
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  input  wire logic [NUM_CH*CNT_W-1:0] cntr_val,
  input  wire logic [NUM_CH-1:0]       ch_mask,
  input  wire logic                    snap_req,
  cntr_byte_readout_if.master          bus,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         snap_drop
);

  localparam int NUM_BYTES = (CNT_W + 7) / 8;
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int PAD_W     = NUM_BYTES * 8;
  localparam logic [BYTE_W-1:0] C_LAST_BYTE = BYTE_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [NUM_CH*CNT_W-1:0]   r_shadow;
  logic [NUM_CH-1:0]         r_mask;
  logic [CH_W-1:0]           r_ch;
  logic [BYTE_W-1:0]         r_byte;
  logic                      r_snap_drop;

  logic [CH_W-1:0]           w_ch_nxt;
  logic [BYTE_W-1:0]         w_byte_nxt;
  logic                      w_snap_take;
  logic [CH_W-1:0]           w_first_ch;
  logic                      w_first_found;
  logic [CH_W-1:0]           w_next_ch;
  logic                      w_next_found;
  logic                      w_byte_top;
  logic [CNT_W-1:0]          w_ch_val;
  logic [PAD_W-1:0]          w_padded;
  logic [7:0]                w_byte_sel;

  // Lowest enabled channel of the live mask, used as the frame start.
  // Scanning downwards lets the lowest set bit win.
  always_comb begin
    w_first_ch = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (ch_mask[c]) begin
        w_first_ch = CH_W'(c);
      end
    end
  end

  assign w_first_found = |ch_mask;

  // Next enabled channel strictly above the current one in the latched mask.
  // Disabled channels are jumped over here, so none of them costs a cycle.
  always_comb begin
    w_next_found = 1'b0;
    w_next_ch    = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (r_mask[c] && (CH_W'(c) > r_ch)) begin
        w_next_found = 1'b1;
        w_next_ch    = CH_W'(c);
      end
    end
  end

  assign w_byte_top = (r_byte == C_LAST_BYTE);

  // Byte selection from the shadow copy only. Bits above CNT_W-1 are zero.
  always_comb begin
    w_ch_val = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (CH_W'(c) == r_ch) begin
        w_ch_val = r_shadow[c*CNT_W +: CNT_W];
      end
    end
  end

  always_comb begin
    w_padded              = '0;
    w_padded[CNT_W-1:0]   = w_ch_val;
  end

  always_comb begin
    w_byte_sel = 8'h00;
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (BYTE_W'(b) == r_byte) begin
        w_byte_sel = w_padded[b*8 +: 8];
      end
    end
  end

  // Next-state and datapath-next logic
  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_byte_nxt  = r_byte;
    w_snap_take = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (snap_req) begin
          w_snap_take = 1'b1;
          w_byte_nxt  = '0;
          if (w_first_found) begin
            w_state_nxt = ST_SEND;
            w_ch_nxt    = w_first_ch;
          end else begin
            w_state_nxt = ST_DONE;
            w_ch_nxt    = '0;
          end
        end
      end
      ST_SEND: begin
        if (bus.rd_ready) begin
          if (!w_byte_top) begin
            w_byte_nxt = r_byte + 1'b1;
          end else begin
            w_byte_nxt = '0;
            if (w_next_found) begin
              w_ch_nxt = w_next_ch;
            end else begin
              w_state_nxt = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath registers. The shadow and mask load only on an accepted
  // snapshot, so input activity during a frame never reaches the stream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ch        <= '0;
      r_byte      <= '0;
      r_shadow    <= '0;
      r_mask      <= '0;
      r_snap_drop <= 1'b0;
    end else begin
      r_ch        <= w_ch_nxt;
      r_byte      <= w_byte_nxt;
      r_snap_drop <= snap_req && (r_state != ST_IDLE);
      if (w_snap_take) begin
        r_shadow <= cntr_val;
        r_mask   <= ch_mask;
      end
    end
  end

  // Every output decodes registers only. There is no input-to-output path.
  assign bus.byte_valid = (r_state == ST_SEND);
  assign bus.byte_out   = (r_state == ST_SEND) ? w_byte_sel : 8'h00;
  assign bus.byte_ch    = r_ch;
  assign bus.byte_idx   = r_byte;
  assign bus.byte_last  = (r_state == ST_SEND) && w_byte_top && !w_next_found;
  assign busy           = (r_state != ST_IDLE);
  assign frame_done     = (r_state == ST_DONE);
  assign snap_drop      = r_snap_drop;

endmodule
`default_nettype wire

// File: tb/tb_cntr_byte_readout.sv
`default_nettype none
// ============================================================================
// Module   : tb_cntr_byte_readout
// Purpose  : Self-checking bench for cntr_byte_readout. The main instance
//            (4 x 27) is checked against a scoreboard of expected bytes. Two
//            extra instances (1 x 8, 3 x 33) cover the parameter corners.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cntr_byte_readout;

  typedef struct packed {
    logic [7:0] b;
    logic [1:0] ch;
    logic [1:0] idx;
    logic       last;
  } beat_t;

  logic         clk;
  logic         rst_n;
  logic [107:0] cntr_val;
  logic [3:0]   ch_mask;
  logic         snap_req;
  logic         busy, frame_done, snap_drop;

  logic [7:0]   c1_val;
  logic         m1, s1, busy1, done1, drop1;
  logic [98:0]  c3_val;
  logic [2:0]   m3;
  logic         s3, busy3, done3, drop3;

  int n_assert = 0;
  int n_fail   = 0;
  int n_xfer   = 0;

  beat_t       sb[$];
  beat_t       mon_got, mon_exp;
  logic [26:0] model_val [4];

  cntr_byte_readout_if #(.NUM_CH(4), .CNT_W(27)) m_if ();
  cntr_byte_readout_if #(.NUM_CH(1), .CNT_W(8))  if1 ();
  cntr_byte_readout_if #(.NUM_CH(3), .CNT_W(33)) if3 ();

  cntr_byte_readout #(.NUM_CH(4), .CNT_W(27)) dut (
    .clk(clk), .rst_n(rst_n), .cntr_val(cntr_val), .ch_mask(ch_mask),
    .snap_req(snap_req), .bus(m_if.master), .busy(busy),
    .frame_done(frame_done), .snap_drop(snap_drop)
  );

  cntr_byte_readout #(.NUM_CH(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .cntr_val(c1_val), .ch_mask(m1),
    .snap_req(s1), .bus(if1.master), .busy(busy1),
    .frame_done(done1), .snap_drop(drop1)
  );

  cntr_byte_readout #(.NUM_CH(3), .CNT_W(33)) dut3 (
    .clk(clk), .rst_n(rst_n), .cntr_val(c3_val), .ch_mask(m3),
    .snap_req(s3), .bus(if3.master), .busy(busy3),
    .frame_done(done3), .snap_drop(drop3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every accepted byte of the main instance is popped and compared
  always @(negedge clk) begin
    if (m_if.byte_valid && m_if.rd_ready) begin
      mon_got = {m_if.byte_out, m_if.byte_ch, m_if.byte_idx, m_if.byte_last};
      n_assert++;
      n_xfer++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got byte=%h ch=%0d idx=%0d last=%b, expected no byte",
                 mon_got.b, mon_got.ch, mon_got.idx, mon_got.last);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_got !== mon_exp) begin
          n_fail++;
          $display("FAIL sb_byte: got byte=%h ch=%0d idx=%0d last=%b, expected byte=%h ch=%0d idx=%0d last=%b",
                   mon_got.b, mon_got.ch, mon_got.idx, mon_got.last,
                   mon_exp.b, mon_exp.ch, mon_exp.idx, mon_exp.last);
        end
      end
    end
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  // Reference model: queue the expected bytes of one frame for a given mask
  task automatic push_frame(input logic [3:0] m);
    int    hi;
    beat_t e;
    hi = -1;
    for (int c = 0; c < 4; c++) if (m[c]) hi = c;
    for (int c = 0; c < 4; c++) begin
      if (m[c]) begin
        for (int b = 0; b < 4; b++) begin
          e.b    = 8'(model_val[c] >> (8 * b));
          e.ch   = 2'(c);
          e.idx  = 2'(b);
          e.last = (c == hi) && (b == 3);
          sb.push_back(e);
        end
      end
    end
  endtask

  task automatic load_vals();
    model_val[0] = 27'h5ABCDEF;
    model_val[1] = 27'h0000001;
    model_val[2] = 27'h7FFFFFF;
    model_val[3] = 27'h0123456;
    cntr_val = {model_val[3], model_val[2], model_val[1], model_val[0]};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    snap_req = 1'b0; s1 = 1'b0; s3 = 1'b0;
    m_if.rd_ready = 1'b0; if1.rd_ready = 1'b0; if3.rd_ready = 1'b0;
    cntr_val = '0; ch_mask = '0; c1_val = '0; m1 = 1'b0; c3_val = '0; m3 = '0;
    repeat (3) drive_edge();
    @(negedge clk);
    n_assert++;
    if ({m_if.byte_out, m_if.byte_valid, m_if.byte_ch, m_if.byte_idx, m_if.byte_last} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_bus: got out=%h v=%b ch=%0d idx=%0d last=%b, expected all 0",
               m_if.byte_out, m_if.byte_valid, m_if.byte_ch, m_if.byte_idx, m_if.byte_last);
    end
    n_assert++;
    if ({busy, frame_done, snap_drop} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_status: got busy/done/drop=%b, expected 000", {busy, frame_done, snap_drop});
    end
    drive_edge();
    rst_n = 1'b1;
  endtask

  task automatic test_frames();
    logic [3:0] m;
    int         n, x0;
    load_vals();
    m_if.rd_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      m = (t == 0) ? 4'hF : 4'b1010;
      n = (t == 0) ? 16 : 8;
      ch_mask = m;
      push_frame(m);
      x0 = n_xfer;
      snap_req = 1'b1;
      drive_edge();
      snap_req = 1'b0;
      for (int k = 0; k < n; k++) begin
        @(negedge clk);
        n_assert++;
        if (m_if.byte_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL frame_valid: mask=%h beat %0d got valid=%b, expected 1", m, k, m_if.byte_valid);
        end
        drive_edge();
      end
      @(negedge clk);
      n_assert++;
      if ({m_if.byte_valid, frame_done, busy} !== 3'b011) begin
        n_fail++;
        $display("FAIL frame_end: mask=%h got valid/done/busy=%b, expected 011", m, {m_if.byte_valid, frame_done, busy});
      end
      drive_edge();
      @(negedge clk);
      n_assert++;
      if ({m_if.byte_valid, frame_done, busy} !== 3'b000) begin
        n_fail++;
        $display("FAIL frame_idle: mask=%h got valid/done/busy=%b, expected 000", m, {m_if.byte_valid, frame_done, busy});
      end
      n_assert++;
      if ((n_xfer - x0 !== n) || (sb.size() != 0)) begin
        n_fail++;
        $display("FAIL frame_count: mask=%h got %0d bytes (%0d left), expected %0d", m, n_xfer - x0, sb.size(), n);
      end
      drive_edge();
    end
  endtask

  task automatic test_backpressure();
    logic [3:0]  pat;
    logic [13:0] cur, prev;
    logic        prev_stall, done;
    int          x0, stall_err;
    pat = 4'b1001;  // bit i = rd_ready on cycle i: 1,0,0,1
    load_vals();
    ch_mask = 4'hF;
    push_frame(4'hF);
    x0 = n_xfer; stall_err = 0; prev_stall = 1'b0; done = 1'b0; prev = '0;
    m_if.rd_ready = pat[0];
    snap_req = 1'b1;
    drive_edge();
    snap_req = 1'b0;
    for (int i = 1; i < 200 && !done; i++) begin
      m_if.rd_ready = pat[i % 4];
      @(negedge clk);
      cur = {m_if.byte_out, m_if.byte_ch, m_if.byte_idx, m_if.byte_last, m_if.byte_valid};
      if (prev_stall) begin
        n_assert++;
        if (cur !== prev) begin
          n_fail++; stall_err++;
          $display("FAIL stall_hold: cycle %0d got %h, expected %h", i, cur, prev);
        end
      end
      prev_stall = m_if.byte_valid && !m_if.rd_ready;
      prev = cur;
      done = frame_done;
      drive_edge();
    end
    m_if.rd_ready = 1'b1;
    n_assert++;
    if (!done) begin
      n_fail++;
      $display("FAIL bp_timeout: got no frame_done in 200 cycles, expected frame_done");
    end
    n_assert++;
    if ((n_xfer - x0 !== 16) || (sb.size() != 0)) begin
      n_fail++;
      $display("FAIL bp_count: got %0d bytes (%0d left), expected 16", n_xfer - x0, sb.size());
    end
  endtask

  task automatic test_isolation();
    int   x0, drops;
    logic done;
    load_vals();
    ch_mask = 4'hF;
    m_if.rd_ready = 1'b1;
    push_frame(4'hF);
    x0 = n_xfer; drops = 0; done = 1'b0;
    snap_req = 1'b1;
    drive_edge();
    snap_req = 1'b0;
    for (int i = 1; i < 60 && !done; i++) begin
      cntr_val = 108'({$urandom(), $urandom(), $urandom(), $urandom()});
      ch_mask  = 4'($urandom());
      snap_req = (i == 5);
      @(negedge clk);
      if (snap_drop) drops++;
      done = frame_done;
      drive_edge();
    end
    snap_req = 1'b0;
    n_assert++;
    if (!done || drops != 1) begin
      n_fail++;
      $display("FAIL iso_drop: got done=%b drops=%0d, expected done=1 drops=1", done, drops);
    end
    n_assert++;
    if ((n_xfer - x0 !== 16) || (sb.size() != 0)) begin
      n_fail++;
      $display("FAIL iso_count: got %0d bytes (%0d left), expected 16", n_xfer - x0, sb.size());
    end
    repeat (3) begin
      @(negedge clk);
      n_assert++;
      if ({m_if.byte_valid, busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL iso_restart: got valid/busy=%b, expected 00", {m_if.byte_valid, busy});
      end
      drive_edge();
    end
  endtask

  task automatic test_empty_mask();
    int x0;
    x0 = n_xfer;
    ch_mask = 4'h0;
    snap_req = 1'b1;
    drive_edge();
    snap_req = 1'b0;
    @(negedge clk);
    n_assert++;
    if ({m_if.byte_valid, frame_done, busy} !== 3'b011) begin
      n_fail++;
      $display("FAIL empty_done: got valid/done/busy=%b, expected 011", {m_if.byte_valid, frame_done, busy});
    end
    drive_edge();
    @(negedge clk);
    n_assert++;
    if ({m_if.byte_valid, frame_done, busy, n_xfer - x0 == 0} !== 4'b0001) begin
      n_fail++;
      $display("FAIL empty_idle: got valid/done/busy=%b bytes=%0d, expected 000 and 0",
               {m_if.byte_valid, frame_done, busy}, n_xfer - x0);
    end
    drive_edge();
  endtask

  task automatic test_reset_midframe();
    int x0;
    load_vals();
    ch_mask = 4'hF;
    m_if.rd_ready = 1'b1;
    push_frame(4'hF);
    x0 = n_xfer;
    snap_req = 1'b1;
    drive_edge();
    snap_req = 1'b0;
    repeat (5) drive_edge();
    n_assert++;
    if (n_xfer - x0 !== 5) begin
      n_fail++;
      $display("FAIL rstmid_pre: got %0d bytes before reset, expected 5", n_xfer - x0);
    end
    rst_n = 1'b0;
    m_if.rd_ready = 1'b0;
    drive_edge();
    @(negedge clk);
    n_assert++;
    if ({m_if.byte_out, m_if.byte_valid, m_if.byte_ch, m_if.byte_idx, m_if.byte_last,
         busy, frame_done, snap_drop} !== 17'h0) begin
      n_fail++;
      $display("FAIL rstmid_zero: got out=%h v=%b ch=%0d idx=%0d last=%b busy=%b done=%b drop=%b, expected all 0",
               m_if.byte_out, m_if.byte_valid, m_if.byte_ch, m_if.byte_idx, m_if.byte_last,
               busy, frame_done, snap_drop);
    end
    drive_edge();
    rst_n = 1'b1;
    sb.delete();
    drive_edge();
    @(negedge clk);
    n_assert++;
    if ({frame_done, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL rstmid_nodone: got done/busy=%b, expected 00", {frame_done, busy});
    end
    drive_edge();
    m_if.rd_ready = 1'b1;
    push_frame(4'hF);
    x0 = n_xfer;
    snap_req = 1'b1;
    drive_edge();
    snap_req = 1'b0;
    repeat (16) drive_edge();
    @(negedge clk);
    n_assert++;
    if (!frame_done || (n_xfer - x0 !== 16) || (sb.size() != 0)) begin
      n_fail++;
      $display("FAIL rstmid_refrm: got done=%b bytes=%0d, expected done=1 bytes=16", frame_done, n_xfer - x0);
    end
    drive_edge();
  endtask

  task automatic test_param_sweep();
    logic [32:0] v3 [3];
    logic [14:0] exp3 [$];
    logic [14:0] got3, e3;
    // 1 channel x 8 bits: one byte per frame, which is also the last byte
    c1_val = 8'hA5; m1 = 1'b1; if1.rd_ready = 1'b1;
    s1 = 1'b1;
    drive_edge();
    s1 = 1'b0;
    @(negedge clk);
    n_assert++;
    if ({if1.byte_valid, if1.byte_out, if1.byte_ch, if1.byte_idx, if1.byte_last} !== {1'b1, 8'hA5, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL p1_byte: got v=%b out=%h idx=%0d last=%b, expected v=1 out=a5 idx=0 last=1",
               if1.byte_valid, if1.byte_out, if1.byte_idx, if1.byte_last);
    end
    drive_edge();
    @(negedge clk);
    n_assert++;
    if ({if1.byte_valid, done1} !== 2'b01) begin
      n_fail++;
      $display("FAIL p1_done: got valid/done=%b, expected 01", {if1.byte_valid, done1});
    end
    drive_edge();
    // 3 channels x 33 bits: five bytes per channel, top byte carries bit 32 only
    v3[0] = 33'h1_2345_6789;
    v3[1] = 33'h0_DEAD_BEEF;
    v3[2] = 33'h1_FFFF_FFFF;
    c3_val = {v3[2], v3[1], v3[0]};
    m3 = 3'b101;
    for (int c = 0; c < 3; c += 2)
      for (int b = 0; b < 5; b++)
        exp3.push_back({1'b1, 8'(v3[c] >> (8 * b)), 2'(c), 3'(b), (c == 2) && (b == 4)});
    if3.rd_ready = 1'b1;
    s3 = 1'b1;
    drive_edge();
    s3 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      got3 = {if3.byte_valid, if3.byte_out, if3.byte_ch, if3.byte_idx, if3.byte_last};
      e3 = exp3.pop_front();
      n_assert++;
      if (got3 !== e3) begin
        n_fail++;
        $display("FAIL p3_byte: beat %0d got v=%b out=%h ch=%0d idx=%0d last=%b, expected v=%b out=%h ch=%0d idx=%0d last=%b",
                 k, got3[14], got3[13:6], got3[5:4], got3[3:1], got3[0],
                 e3[14], e3[13:6], e3[5:4], e3[3:1], e3[0]);
      end
      drive_edge();
    end
    @(negedge clk);
    n_assert++;
    if ({if3.byte_valid, done3} !== 2'b01) begin
      n_fail++;
      $display("FAIL p3_done: got valid/done=%b, expected 01", {if3.byte_valid, done3});
    end
    drive_edge();
  endtask

  initial begin
    test_reset();
    test_frames();
    test_backpressure();
    test_isolation();
    test_empty_mask();
    test_reset_midframe();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running at 200000, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
